data_ram_rsp: RTL and testbench
===============================

DATA_RAM_RSP -- requirements
Module: data_ram_rsp

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 10, word-address width (1024 words).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, wait states per access (range 0-15).
REQ-003 The block SHALL have port clk  input  1  rising-edge clock.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port mem_ce_i  input  1  access request from memory stage; held until ack.
REQ-006 The block SHALL have port mem_we_i  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port mem_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 The block SHALL have port mem_sel_i  input  4  byte enables; sel[3] maps to data[31:24] (big-endian lanes).
REQ-009 The block SHALL have port mem_data_i  input  32  store data.
REQ-010 The block SHALL have port mem_data_o  output  32  load data, valid while mem_ack_o = 1.
REQ-011 The block SHALL have port mem_ack_o  output  1  single-cycle completion pulse.
REQ-012 The block SHALL have port mem_err_o  output  1  access error, valid while mem_ack_o = 1.
REQ-013 The block SHALL have port stallreq_o  output  1  pipeline stall request to control unit.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, WAIT, RESP.
REQ-015 In IDLE with mem_ce_i = 1, the block SHALL capture we, addr, sel and data into internal registers, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP when WAIT_CYCLES = 0.
REQ-016 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter equals 1.
REQ-017 RESP SHALL last exactly one cycle, then the FSM SHALL return to IDLE regardless of mem_ce_i.
REQ-018 Latency SHALL be fixed: for a request first presented in cycle N (FSM in IDLE), mem_ack_o SHALL be 1 in cycle N+1+WAIT_CYCLES.
REQ-019 stallreq_o SHALL be combinational: 1 when (IDLE and mem_ce_i = 1) or in WAIT, and 0 in RESP.
REQ-020 A request that is still asserted in the cycle after RESP SHALL be treated as a new access.
REQ-021 Captured values SHALL be used for the whole access; input changes after capture SHALL be ignored.
REQ-022 Legal sel values SHALL be 4'b1111, 4'b1100, 4'b0011, 4'b1000, 4'b0100, 4'b0010 and 4'b0001; any other value SHALL be an error.
REQ-023 An address with any bit of mem_addr_i[31:ADDR_WIDTH+2] set SHALL be an error.
REQ-024 A store SHALL write only the enabled byte lanes of word mem_addr_i[ADDR_WIDTH+1:2], on the WAIT->RESP edge (or IDLE->RESP edge), exactly once.
REQ-025 A load SHALL return the full addressed word on mem_data_o in RESP, independent of sel.
REQ-026 An errored access SHALL follow the same FSM and latency, SHALL assert mem_err_o = 1 with mem_ack_o, SHALL perform no write, and SHALL drive mem_data_o = 0.
REQ-027 Outside RESP, mem_ack_o = 0, mem_err_o = 0 and mem_data_o = 32'h0 SHALL hold.
REQ-028 A load that follows a store to the same word SHALL return the newly written data.
REQ-029 RAM contents SHALL be unspecified after power-up and SHALL NOT be cleared by rst.

Reset
REQ-030 When rst = 1 at a rising edge, the FSM SHALL go to IDLE, the counter and captured registers SHALL clear, and mem_ack_o = 0, mem_err_o = 0, mem_data_o = 0.
REQ-031 While rst = 1, stallreq_o SHALL be 0 regardless of mem_ce_i.
REQ-032 A reset during WAIT SHALL abort the access: no write and no ack.
REQ-033 After rst deasserts, a still-asserted mem_ce_i SHALL be treated as a new request.

Verification
REQ-034 Scenario: WAIT_CYCLES = 2; store addr 0x10, sel 1111, data 0xDEADBEEF, then load addr 0x10 -> each access gives ack 3 cycles after first presentation, stallreq high for the 3 preceding cycles, and the load returns 0xDEADBEEF with err = 0.
REQ-035 Scenario: after REQ-034, store sel 0100, data 0x00AA0000 to addr 0x10, then load -> 0xDEAABEEF.
REQ-036 Scenario: load with sel 0110, and separately store to addr 0x0000_1000 (ADDR_WIDTH = 10) -> ack with err = 1, data_o = 0, and a subsequent load of word 0 is unchanged.
REQ-037 Scenario: WAIT_CYCLES = 0; back-to-back loads with ce held high -> ack in every second cycle, stallreq = 0 in each ack cycle.
REQ-038 Scenario: store issued, rst pulsed while FSM in WAIT -> no ack, stallreq = 0 during reset, and the target word keeps its old value on read-back.
REQ-039 Scenario: change mem_addr_i and mem_data_i during WAIT -> the access completes using the originally captured values.

Source files
------------

// File: rtl/data_ram_rsp.sv
// data_ram_rsp: single-port word RAM answering memory-stage requests after a
// fixed number of wait states. Each access is captured once, checked for an
// illegal byte-enable pattern or out-of-range address, and completed with a
// one-cycle ack (plus err on a bad access). Stores write only enabled lanes.
module data_ram_rsp #(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [31:0] mem_addr_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        mem_ack_o,
   output logic        mem_err_o,
   output logic        stallreq_o
);

   localparam int         DEPTH     = 1 << ADDR_WIDTH;
   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    we_q;
   logic [ADDR_WIDTH-1:0]   word_q;
   logic [3:0]              sel_q;
   logic [31:0]             data_q;
   logic                    err_q;

   // Word storage; deliberately never cleared by rst.
   logic [31:0]             ram [DEPTH];

   // Access attributes as seen on the completing edge.
   logic                    acc_we;
   logic                    acc_err;
   logic [ADDR_WIDTH-1:0]   acc_word;
   logic [3:0]              acc_sel;
   logic [31:0]             acc_data;
   logic                    fire;
   logic [31:0]             rd_word;

   // Byte, aligned halfword and full word are the only legal lane patterns.
   function automatic logic sel_legal(input logic [3:0] sel);
      case (sel)
         4'b1111, 4'b1100, 4'b0011,
         4'b1000, 4'b0100, 4'b0010, 4'b0001: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   // Any byte-address bit above the RAM's range makes the access illegal.
   function automatic logic addr_legal(input logic [31:0] addr);
      return (addr >> (ADDR_WIDTH + 2)) == 32'd0;
   endfunction

   // sel[i] enables byte lane data[8*i+7:8*i], so sel[3] owns data[31:24].
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++)
         res[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      return res;
   endfunction

   // With zero wait states the access completes straight out of IDLE, before
   // the capture registers are loaded, so the live inputs are used there.
   always_comb begin
      acc_we   = we_q;
      acc_word = word_q;
      acc_sel  = sel_q;
      acc_data = data_q;
      acc_err  = err_q;
      if (state == IDLE) begin
         acc_we   = mem_we_i;
         acc_word = mem_addr_i[ADDR_WIDTH+1:2];
         acc_sel  = mem_sel_i;
         acc_data = mem_data_i;
         acc_err  = !sel_legal(mem_sel_i) || !addr_legal(mem_addr_i);
      end
   end

   // fire marks the edge that enters RESP; reset suppresses it so an aborted
   // access neither writes nor acks.
   assign fire = !rst && ((state == IDLE && mem_ce_i && NO_WAIT) ||
                          (state == WAIT && cnt == 4'd1));

   assign rd_word = (acc_we || acc_err) ? 32'h0 : ram[acc_word];

   assign stallreq_o = !rst && ((state == IDLE && mem_ce_i) || state == WAIT);

   // Access sequencer: capture, count wait states, emit a one-cycle response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         word_q     <= '0;
         sel_q      <= 4'd0;
         data_q     <= 32'h0;
         err_q      <= 1'b0;
         mem_ack_o  <= 1'b0;
         mem_err_o  <= 1'b0;
         mem_data_o <= 32'h0;
      end else begin
         mem_ack_o  <= 1'b0;
         mem_err_o  <= 1'b0;
         mem_data_o <= 32'h0;
         case (state)
            IDLE: begin
               if (mem_ce_i) begin
                  we_q   <= mem_we_i;
                  word_q <= acc_word;
                  sel_q  <= mem_sel_i;
                  data_q <= mem_data_i;
                  err_q  <= acc_err;
                  cnt    <= WAIT_INIT;
                  state  <= NO_WAIT ? RESP : WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
         if (fire) begin
            mem_ack_o  <= 1'b1;
            mem_err_o  <= acc_err;
            mem_data_o <= rd_word;
         end
      end
   end

   // Lane-masked write, performed once on the edge that enters RESP.
   always_ff @(posedge clk) begin
      if (fire && acc_we && !acc_err)
         ram[acc_word] <= merge_lanes(ram[acc_word], acc_data, acc_sel);
   end

endmodule

// File: tb/tb_data_ram_rsp.sv
// Directed bench for data_ram_rsp: one instance with two wait states and one
// with none, driven by scenario tasks with hand-computed expectations.
module tb_data_ram_rsp;

   logic        clk;
   logic        rst;

   logic        ce, we;
   logic [31:0] addr, wdata;
   logic [3:0]  sel;
   logic [31:0] rdata;
   logic        ack, err, stall;

   logic        ce0, we0;
   logic [31:0] addr0, wdata0;
   logic [3:0]  sel0;
   logic [31:0] rdata0;
   logic        ack0, err0, stall0;

   int checks;
   int errors;

   data_ram_rsp #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .mem_ce_i   (ce),
      .mem_we_i   (we),
      .mem_addr_i (addr),
      .mem_sel_i  (sel),
      .mem_data_i (wdata),
      .mem_data_o (rdata),
      .mem_ack_o  (ack),
      .mem_err_o  (err),
      .stallreq_o (stall)
   );

   data_ram_rsp #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .mem_ce_i   (ce0),
      .mem_we_i   (we0),
      .mem_addr_i (addr0),
      .mem_sel_i  (sel0),
      .mem_data_i (wdata0),
      .mem_data_o (rdata0),
      .mem_ack_o  (ack0),
      .mem_err_o  (err0),
      .stallreq_o (stall0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drives one access on the two-wait-state instance starting in an IDLE
   // cycle and reports what was observed; callers do the comparisons.
   task automatic access(input logic a_we, input logic [31:0] a_addr,
                         input logic [3:0] a_sel, input logic [31:0] a_data,
                         input bit scramble,
                         output int lat, output logic stall_all,
                         output logic stall_ack, output logic [31:0] rd,
                         output logic er);
      ce = 1'b1; we = a_we; addr = a_addr; sel = a_sel; wdata = a_data;
      lat = 0;
      stall_all = 1'b1;
      while (lat < 20) begin
         @(negedge clk);
         if (ack) break;
         if (!stall) stall_all = 1'b0;
         @(posedge clk); #1;
         lat++;
         if (scramble) begin
            addr  = a_addr ^ 32'h4;
            wdata = ~a_data;
            sel   = 4'b0110;
            we    = ~a_we;
         end
      end
      stall_ack = stall;
      rd = rdata;
      er = err;
      @(posedge clk); #1;
      ce = 1'b0;
   endtask

   task automatic test_reset();
      int lat; logic sa, sk, e; logic [31:0] d;
      rst = 1'b1; ce = 1'b1; we = 1'b0; addr = 32'h0; sel = 4'hF; wdata = 32'h0;
      ce0 = 1'b1; we0 = 1'b0; addr0 = 32'h0; sel0 = 4'hF; wdata0 = 32'h0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
      checks++;
      if (ack !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL reset_ack_err got %b%b exp 00", ack, err); end
      checks++;
      if (rdata !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 00000000", rdata); end
      checks++;
      if (stall0 !== 1'b0 || ack0 !== 1'b0) begin errors++; $display("FAIL reset_dut0 got %b%b exp 00", stall0, ack0); end
      @(posedge clk); #1;
      rst = 1'b0; ce0 = 1'b0;
      // ce held through reset: first non-reset cycle is a new request.
      access(1'b0, 32'h0, 4'hF, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL post_reset_latency got %0d exp 3", lat); end
      checks++;
      if (sa !== 1'b1) begin errors++; $display("FAIL post_reset_stall got %b exp 1", sa); end
   endtask

   task automatic test_store_load();
      int lat; logic sa, sk, e; logic [31:0] d;
      access(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL store_latency got %0d exp 3", lat); end
      checks++;
      if (sa !== 1'b1 || sk !== 1'b0) begin errors++; $display("FAIL store_stall got %b/%b exp 1/0", sa, sk); end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL store_err got %b exp 0", e); end
      @(negedge clk);
      checks++;
      if (ack !== 1'b0 || rdata !== 32'h0) begin errors++; $display("FAIL ack_single_cycle got ack %b data %h exp 0 00000000", ack, rdata); end
      @(posedge clk); #1;
      access(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (lat !== 3) begin errors++; $display("FAIL load_latency got %0d exp 3", lat); end
      checks++;
      if (sa !== 1'b1 || sk !== 1'b0) begin errors++; $display("FAIL load_stall got %b/%b exp 1/0", sa, sk); end
      checks++;
      if (d !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL load_data got %h err %b exp deadbeef err 0", d, e); end
   endtask

   task automatic test_byte_lanes();
      int lat; logic sa, sk, e; logic [31:0] d;
      access(1'b1, 32'h10, 4'b0100, 32'h00AA0000, 1'b0, lat, sa, sk, d, e);
      access(1'b0, 32'h10, 4'b0001, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'hDEAABEEF) begin errors++; $display("FAIL lane_byte2 got %h exp deaabeef", d); end
      access(1'b1, 32'h12, 4'b0011, 32'hFFFF1234, 1'b0, lat, sa, sk, d, e);
      access(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'hDEAA1234) begin errors++; $display("FAIL lane_half_lo got %h exp deaa1234", d); end
      access(1'b1, 32'h10, 4'b1000, 32'h55667788, 1'b0, lat, sa, sk, d, e);
      access(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'h55AA1234) begin errors++; $display("FAIL lane_byte3 got %h exp 55aa1234", d); end
   endtask

   task automatic test_errors();
      int lat; logic sa, sk, e; logic [31:0] d;
      access(1'b1, 32'h0, 4'b1111, 32'h01234567, 1'b0, lat, sa, sk, d, e);
      access(1'b0, 32'h0, 4'b0110, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_bad_sel got lat %0d err %b data %h exp 3 1 00000000", lat, e, d); end
      access(1'b1, 32'h0000_1000, 4'b1111, 32'hFFFFFFFF, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (lat !== 3 || e !== 1'b1 || d !== 32'h0) begin errors++; $display("FAIL err_bad_addr got lat %0d err %b data %h exp 3 1 00000000", lat, e, d); end
      access(1'b1, 32'h0, 4'b0101, 32'hFFFFFFFF, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL err_store_sel got %b exp 1", e); end
      access(1'b0, 32'h0, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'h01234567 || e !== 1'b0) begin errors++; $display("FAIL err_no_write got %h err %b exp 01234567 0", d, e); end
   endtask

   task automatic test_back_to_back();
      ce0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; sel0 = 4'hF; wdata0 = 32'hCAFEF00D;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if (ack0 !== (i % 2 == 1) || stall0 !== (i % 2 == 0)) begin
            errors++; $display("FAIL b2b_store cycle %0d got ack %b stall %b", i, ack0, stall0);
         end
         @(posedge clk); #1;
      end
      we0 = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (ack0 !== (i % 2 == 1) || stall0 !== (i % 2 == 0)) begin
            errors++; $display("FAIL b2b_load cycle %0d got ack %b stall %b", i, ack0, stall0);
         end
         checks++;
         if (rdata0 !== ((i % 2 == 1) ? 32'hCAFEF00D : 32'h0) || err0 !== 1'b0) begin
            errors++; $display("FAIL b2b_data cycle %0d got %h err %b", i, rdata0, err0);
         end
         @(posedge clk); #1;
      end
      ce0 = 1'b0;
   endtask

   task automatic test_reset_abort();
      int lat; logic sa, sk, e; logic [31:0] d;
      logic saw_ack;
      ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF; wdata = 32'h0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall got %b exp 0", stall); end
      @(posedge clk); #1;
      rst = 1'b0; ce = 1'b0;
      saw_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (ack) saw_ack = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (saw_ack !== 1'b0) begin errors++; $display("FAIL abort_no_ack got %b exp 0", saw_ack); end
      access(1'b0, 32'h10, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'h55AA1234) begin errors++; $display("FAIL abort_no_write got %h exp 55aa1234", d); end
   endtask

   task automatic test_capture();
      int lat; logic sa, sk, e; logic [31:0] d;
      access(1'b1, 32'h24, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      access(1'b1, 32'h20, 4'b1111, 32'h13579BDF, 1'b1, lat, sa, sk, d, e);
      checks++;
      if (lat !== 3 || e !== 1'b0) begin errors++; $display("FAIL capture_store got lat %0d err %b exp 3 0", lat, e); end
      access(1'b0, 32'h20, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'h13579BDF) begin errors++; $display("FAIL capture_word got %h exp 13579bdf", d); end
      access(1'b0, 32'h24, 4'b1111, 32'h0, 1'b0, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'h0) begin errors++; $display("FAIL capture_neighbour got %h exp 00000000", d); end
      access(1'b0, 32'h20, 4'b1111, 32'h0, 1'b1, lat, sa, sk, d, e);
      checks++;
      if (d !== 32'h13579BDF || e !== 1'b0) begin errors++; $display("FAIL capture_load got %h err %b exp 13579bdf 0", d, e); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_store_load();
      test_byte_lanes();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      test_capture();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
